hssl_tx_align_gen: RTL and testbench
====================================

// Module: hssl_tx_align_gen
// PURPOSE
//  Transmit-side alignment generator between the HSSL tx frame source and the transceiver tx port.
//  Emits a comma burst after reset or on request, then passes frames with 1-cycle registered latency.
//  Under saturated traffic it forces a comma word at least every ALIGN_PERIOD cycles.
//  This lets the far-end receiver's loss-of-sync machine (comma detect -> RESYNC -> SYNC_ACQUIRED) lock and stay locked.
// PARAMETERS
//  BURST_LEN    16  comma words sent per burst (>=1)
//  ALIGN_PERIOD 256 max cycles between consecutive comma words on tx_data_out (>=2)
// PORTS
//  clk               in   1   single clock
//  reset_n           in   1   asynchronous, active-low reset
//  txdata_in         in   32  frame word from frame source
//  txcharisk_in      in   4   per-byte K flags of txdata_in
//  txvld_in          in   1   txdata_in valid
//  txrdy_out         out  1   block accepts txdata_in this cycle
//  resync_req_in     in   1   pulse: restart comma burst
//  tx_data_out       out  32  transceiver tx data
//  tx_charisk_out    out  8   transceiver K flags; [7:4] always 0
//  align_state_out   out  2   2'b01 BURST, 2'b00 RUN
//  forced_cnt_out    out  16  forced-comma count (see CONFIGURATION)
// BEHAVIOUR
//  Comma word (pkg): ALIGN_WORD=32'h4A4A4ABC (K28.5 in byte 0), ALIGN_KCHR=4'b0001.
//  Reset (reset_n low, async):
//   - state=BURST, burst_cnt=0, period_cnt=0.
//   - tx_data_out=ALIGN_WORD, tx_charisk_out=8'h01, txrdy_out=0, align_state_out=2'b01, forced_cnt_out=0.
//  txrdy_out = (state==RUN) && !force. It is combinational from registered state only, with no path from txvld_in.
//  Transfer occurs when txvld_in && txrdy_out. On transfer, the next cycle shows tx_data_out=txdata_in and tx_charisk_out={4'h0,txcharisk_in}.
//   - Latency is exactly 1 cycle.
//  No transfer (idle, BURST or force): the next cycle shows ALIGN_WORD/8'h01.
//  A cycle counts as a comma if the registered output is ALIGN_WORD with charisk[0]=1.
//   - This includes a source word equal to ALIGN_WORD/0001.
//  period_cnt: cleared on any comma cycle, otherwise +1.
//   - force = (period_cnt == ALIGN_PERIOD-2), so no run of non-comma words exceeds ALIGN_PERIOD-1.
//   - Width is $clog2(ALIGN_PERIOD); it never wraps.
//  FSM:
//   - BURST: txrdy_out=0; burst_cnt +1 per cycle; at burst_cnt==BURST_LEN-1 -> RUN and burst_cnt clears.
//   - RUN: pass/idle/force as above; resync_req_in=1 -> BURST with burst_cnt=0.
//   - resync_req_in in BURST restarts the count (burst_cnt=0).
//   - Illegal state -> BURST.
//  Simultaneous resync_req_in and force: BURST wins; no forced count increment.
//  A frame word accepted in the same cycle resync_req_in rises is still emitted; the first burst comma follows it.
//  txvld_in held high against txrdy_out=0 is legal; the source holds the data stable.
//  Reset mid-frame drops any in-flight word, and the output returns to ALIGN_WORD immediately.
// CONFIGURATION
//  Macro HSSL_TX_ALIGN_STATS_EN.
//   - Defined: forced_cnt_out increments on each cycle where force=1 in RUN, saturating at 16'hFFFF.
//   - Undefined: forced_cnt_out is tied to 16'h0000, and no counter logic is synthesised.
//   - All other behaviour is identical in both builds.
// STRUCTURE
//  Package hssl_tx_align_pkg:
//   - K28_5=8'hBC, ALIGN_WORD, ALIGN_KCHR.
//   - align_state_t enum {RUN_ST=2'b00, BURST_ST=2'b01}.
//  Sub-module hssl_tx_align_timer:
//   - Contains period_cnt, comma detect and force generation (parameter ALIGN_PERIOD).
//  Top level holds the FSM, burst counter, output registers and the optional stats counter.
// TESTING
//  T1 reset release, txvld_in=0, BURST_LEN=16:
//   - 16 cycles of ALIGN_WORD/8'h01 with txrdy_out=0, then align_state_out=00 and txrdy_out=1.
//  T2 RUN, single word 32'h12345678/4'h0:
//   - Appears on tx_data_out exactly 1 cycle after the transfer; ALIGN_WORD on the following cycle.
//  T3 saturated source, ALIGN_PERIOD=8, distinct non-comma words:
//   - txrdy_out low 1 cycle in every 8; no more than 7 consecutive non-comma outputs.
//   - No word lost or duplicated; forced_cnt_out increments per insertion (STATS_EN build).
//  T4 resync_req_in pulse in RUN, mid-stream:
//   - Accepted word emitted, then 16 commas; resync again at burst cycle 10 gives 16 more from restart.
//  T5 source sends ALIGN_WORD/0001 every 4 cycles, ALIGN_PERIOD=8:
//   - No forced insertion occurs; txrdy_out stays high.
//  T6 reset_n asserted mid-stream:
//   - Outputs return to ALIGN_WORD/8'h01, txrdy_out=0 and forced_cnt_out=0 asynchronously; a full burst runs after release.

Source files
------------

// File: rtl/hssl_tx_align_pkg.sv
// Shared constants and types for the HSSL transmit alignment generator.
// The stats counter in the top level is enabled by defining HSSL_TX_ALIGN_STATS_EN.
package hssl_tx_align_pkg;

  localparam logic [7:0]  K28_5      = 8'hBC;
  localparam logic [31:0] ALIGN_WORD = {8'h4A, 8'h4A, 8'h4A, K28_5};
  localparam logic [3:0]  ALIGN_KCHR = 4'b0001;

  typedef enum logic [1:0] {
    RUN_ST   = 2'b00,
    BURST_ST = 2'b01
  } align_state_t;

  // Only the K flag of byte 0 matters: the comma character lives in byte 0.
  function automatic logic is_comma(input logic [31:0] data, input logic k0);
    return (data == ALIGN_WORD) && k0;
  endfunction

endpackage

// File: rtl/hssl_tx_align_timer.sv
// Tracks non-comma run length on the registered tx output and raises force one
// cycle ahead so the next output word is guaranteed to be a comma.
module hssl_tx_align_timer
  import hssl_tx_align_pkg::*;
#(
  parameter int ALIGN_PERIOD = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_tx_data,
  input  logic        i_tx_k0,
  output logic        o_force
);

  localparam int            PW       = $clog2(ALIGN_PERIOD);
  localparam logic [PW-1:0] FORCE_AT = PW'(ALIGN_PERIOD - 2);
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);

  logic [PW-1:0] r_period_cnt;
  logic          w_comma;

  assign w_comma = is_comma(i_tx_data, i_tx_k0);

  // Period counter: peaks at ALIGN_PERIOD-1, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period_cnt <= '0;
    end else if (w_comma) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + CNT_ONE;
    end
  end

  assign o_force = (r_period_cnt == FORCE_AT);

endmodule

// File: rtl/hssl_tx_align_gen.sv
// HSSL tx alignment generator: comma burst after reset/resync, 1-cycle frame pass-through,
// periodic forced commas. Define HSSL_TX_ALIGN_STATS_EN to build the forced-comma counter.
module hssl_tx_align_gen
  import hssl_tx_align_pkg::*;
#(
  parameter int BURST_LEN    = 16,
  parameter int ALIGN_PERIOD = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] txdata_in,
  input  logic [3:0]  txcharisk_in,
  input  logic        txvld_in,
  output logic        txrdy_out,
  input  logic        resync_req_in,
  output logic [31:0] tx_data_out,
  output logic [7:0]  tx_charisk_out,
  output logic [1:0]  align_state_out,
  output logic [15:0] forced_cnt_out
);

  localparam int            BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);

  align_state_t  r_state;
  logic [BW-1:0] r_burst_cnt;
  logic [31:0]   r_tx_data;
  logic [7:0]    r_tx_charisk;
  logic          w_force;
  logic          w_run;
  logic          w_xfer;

  hssl_tx_align_timer #(
    .ALIGN_PERIOD (ALIGN_PERIOD)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_tx_data (r_tx_data),
    .i_tx_k0   (r_tx_charisk[0]),
    .o_force   (w_force)
  );

  // Ready depends only on registered state, never on txvld_in.
  assign w_run     = (r_state == RUN_ST);
  assign txrdy_out = w_run && !w_force;
  assign w_xfer    = txvld_in && txrdy_out;

  // Alignment FSM: resync always wins, including over a pending force.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= BURST_ST;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        BURST_ST: begin
          if (resync_req_in) begin
            r_state     <= BURST_ST;
            r_burst_cnt <= '0;
          end else if (r_burst_cnt == BURST_LAST) begin
            r_state     <= RUN_ST;
            r_burst_cnt <= '0;
          end else begin
            r_state     <= BURST_ST;
            r_burst_cnt <= r_burst_cnt + BURST_ONE;
          end
        end
        RUN_ST: begin
          if (resync_req_in) begin
            r_state     <= BURST_ST;
            r_burst_cnt <= '0;
          end else begin
            r_state     <= RUN_ST;
            r_burst_cnt <= '0;
          end
        end
        default: begin
          r_state     <= BURST_ST;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  // Output register: accepted word or the comma filler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data    <= ALIGN_WORD;
      r_tx_charisk <= {4'h0, ALIGN_KCHR};
    end else if (w_xfer) begin
      r_tx_data    <= txdata_in;
      r_tx_charisk <= {4'h0, txcharisk_in};
    end else begin
      r_tx_data    <= ALIGN_WORD;
      r_tx_charisk <= {4'h0, ALIGN_KCHR};
    end
  end

  assign tx_data_out     = r_tx_data;
  assign tx_charisk_out  = r_tx_charisk;
  assign align_state_out = r_state;

`ifdef HSSL_TX_ALIGN_STATS_EN
  logic [15:0] r_forced_cnt;

  // Saturating count of forced insertions actually taken in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_forced_cnt <= 16'h0000;
    end else if (w_run && w_force && !resync_req_in && (r_forced_cnt != 16'hFFFF)) begin
      r_forced_cnt <= r_forced_cnt + 16'h0001;
    end else begin
      r_forced_cnt <= r_forced_cnt;
    end
  end

  assign forced_cnt_out = r_forced_cnt;
`else
  assign forced_cnt_out = 16'h0000;
`endif

endmodule

// File: tb/tb_hssl_tx_align_gen.sv
// Self-checking bench for hssl_tx_align_gen (BURST_LEN=16, ALIGN_PERIOD=8) using an
// expected-output queue; forced-count checks follow HSSL_TX_ALIGN_STATS_EN.
module tb_hssl_tx_align_gen;

  localparam int          BURST_LEN    = 16;
  localparam int          ALIGN_PERIOD = 8;
  localparam logic [31:0] TB_ALIGN     = 32'h4A4A4ABC;
  localparam logic [39:0] EXP_COMMA    = {32'h4A4A4ABC, 8'h01};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] txdata_in;
  logic [3:0]  txcharisk_in;
  logic        txvld_in;
  logic        txrdy_out;
  logic        resync_req_in;
  logic [31:0] tx_data_out;
  logic [7:0]  tx_charisk_out;
  logic [1:0]  align_state_out;
  logic [15:0] forced_cnt_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_w;

  always #5 clk = ~clk;

  hssl_tx_align_gen #(
    .BURST_LEN    (BURST_LEN),
    .ALIGN_PERIOD (ALIGN_PERIOD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .txdata_in       (txdata_in),
    .txcharisk_in    (txcharisk_in),
    .txvld_in        (txvld_in),
    .txrdy_out       (txrdy_out),
    .resync_req_in   (resync_req_in),
    .tx_data_out     (tx_data_out),
    .tx_charisk_out  (tx_charisk_out),
    .align_state_out (align_state_out),
    .forced_cnt_out  (forced_cnt_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    txvld_in      = 1'b0;
    resync_req_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({tx_data_out, tx_charisk_out} !== EXP_COMMA) begin
      n_err++; $display("FAIL reset_out: got %h expected %h", {tx_data_out, tx_charisk_out}, EXP_COMMA);
    end
    n_vec++;
    if (txrdy_out !== 1'b0) begin
      n_err++; $display("FAIL reset_rdy: got %b expected 0", txrdy_out);
    end
    n_vec++;
    if (align_state_out !== 2'b01) begin
      n_err++; $display("FAIL reset_state: got %b expected 01", align_state_out);
    end
    n_vec++;
    if (forced_cnt_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_forced: got %h expected 0000", forced_cnt_out);
    end
  endtask

  task automatic test_burst_release();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < BURST_LEN; i++) begin
      n_vec++;
      if (txrdy_out !== 1'b0 || align_state_out !== 2'b01 || {tx_data_out, tx_charisk_out} !== EXP_COMMA) begin
        n_err++; $display("FAIL t1_burst cyc %0d: got rdy=%b st=%b out=%h expected rdy=0 st=01 out=%h",
                          i, txrdy_out, align_state_out, {tx_data_out, tx_charisk_out}, EXP_COMMA);
      end
      tick();
    end
    n_vec++;
    if (txrdy_out !== 1'b1 || align_state_out !== 2'b00) begin
      n_err++; $display("FAIL t1_run: got rdy=%b st=%b expected rdy=1 st=00", txrdy_out, align_state_out);
    end
  endtask

  task automatic test_single_word();
    idle(2);
    n_vec++;
    if (txrdy_out !== 1'b1) begin
      n_err++; $display("FAIL t2_rdy: got %b expected 1", txrdy_out);
    end
    txdata_in    = 32'h12345678;
    txcharisk_in = 4'h0;
    txvld_in     = 1'b1;
    exp_q.push_back({32'h12345678, 8'h00});
    tick();
    txvld_in = 1'b0;
    exp_q.push_back(EXP_COMMA);
    exp_w = exp_q.pop_front();
    n_vec++;
    if ({tx_data_out, tx_charisk_out} !== exp_w) begin
      n_err++; $display("FAIL t2_word: got %h expected %h", {tx_data_out, tx_charisk_out}, exp_w);
    end
    tick();
    exp_w = exp_q.pop_front();
    n_vec++;
    if ({tx_data_out, tx_charisk_out} !== exp_w) begin
      n_err++; $display("FAIL t2_after: got %h expected %h", {tx_data_out, tx_charisk_out}, exp_w);
    end
  endtask

  task automatic test_saturated();
    int          idx;
    int          run;
    int          maxrun;
    logic        exp_rdy;
    logic [15:0] f0;
    logic [15:0] exp_delta;
    idx = 0; run = 0; maxrun = 0;
    idle(2);
    f0 = forced_cnt_out;
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        exp_w = exp_q.pop_front();
        n_vec++;
        if ({tx_data_out, tx_charisk_out} !== exp_w) begin
          n_err++; $display("FAIL t3_data cyc %0d: got %h expected %h", i, {tx_data_out, tx_charisk_out}, exp_w);
        end
      end
      if (tx_data_out == TB_ALIGN && tx_charisk_out[0]) run = 0;
      else run++;
      if (run > maxrun) maxrun = run;
      if (i == 40) break;
      exp_rdy = ((i % ALIGN_PERIOD) != (ALIGN_PERIOD - 1));
      n_vec++;
      if (txrdy_out !== exp_rdy) begin
        n_err++; $display("FAIL t3_rdy cyc %0d: got %b expected %b", i, txrdy_out, exp_rdy);
      end
      txvld_in     = 1'b1;
      txdata_in    = 32'hA5000000 + idx;
      txcharisk_in = 4'h0;
      if (exp_rdy) begin
        exp_q.push_back({txdata_in, 8'h00});
        idx++;
      end else begin
        exp_q.push_back(EXP_COMMA);
      end
      tick();
      if (i == 39) txvld_in = 1'b0;
    end
    n_vec++;
    if (maxrun > ALIGN_PERIOD - 1) begin
      n_err++; $display("FAIL t3_run: got %0d consecutive non-comma, expected at most %0d", maxrun, ALIGN_PERIOD - 1);
    end
`ifdef HSSL_TX_ALIGN_STATS_EN
    exp_delta = 16'd5;
`else
    exp_delta = 16'd0;
`endif
    n_vec++;
    if (forced_cnt_out - f0 !== exp_delta) begin
      n_err++; $display("FAIL t3_forced: got delta %0d expected %0d", forced_cnt_out - f0, exp_delta);
    end
  endtask

  task automatic test_resync();
    int         idx;
    logic       exp_rdy;
    logic [1:0] exp_st;
    idx = 0;
    idle(2);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        exp_w = exp_q.pop_front();
        n_vec++;
        if ({tx_data_out, tx_charisk_out} !== exp_w) begin
          n_err++; $display("FAIL t4_data cyc %0d: got %h expected %h", i, {tx_data_out, tx_charisk_out}, exp_w);
        end
      end
      exp_rdy = (i < 3) || (i >= 30);
      exp_st  = (i >= 3 && i < 30) ? 2'b01 : 2'b00;
      n_vec++;
      if (txrdy_out !== exp_rdy || align_state_out !== exp_st) begin
        n_err++; $display("FAIL t4_ctl cyc %0d: got rdy=%b st=%b expected rdy=%b st=%b",
                          i, txrdy_out, align_state_out, exp_rdy, exp_st);
      end
      resync_req_in = (i == 2 || i == 13);
      txvld_in      = 1'b1;
      txdata_in     = 32'hB0000000 + idx;
      txcharisk_in  = 4'h0;
      if (exp_rdy) begin
        exp_q.push_back({txdata_in, 8'h00});
        idx++;
      end else begin
        exp_q.push_back(EXP_COMMA);
      end
      tick();
    end
    resync_req_in = 1'b0;
    txvld_in      = 1'b0;
    exp_w = exp_q.pop_front();
    n_vec++;
    if ({tx_data_out, tx_charisk_out} !== exp_w) begin
      n_err++; $display("FAIL t4_last: got %h expected %h", {tx_data_out, tx_charisk_out}, exp_w);
    end
  endtask

  task automatic test_comma_source();
    logic [15:0] f0;
    idle(2);
    f0 = forced_cnt_out;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        exp_w = exp_q.pop_front();
        n_vec++;
        if ({tx_data_out, tx_charisk_out} !== exp_w) begin
          n_err++; $display("FAIL t5_data cyc %0d: got %h expected %h", i, {tx_data_out, tx_charisk_out}, exp_w);
        end
      end
      n_vec++;
      if (txrdy_out !== 1'b1) begin
        n_err++; $display("FAIL t5_rdy cyc %0d: got %b expected 1", i, txrdy_out);
      end
      if ((i % 4) == 3) begin
        txdata_in    = TB_ALIGN;
        txcharisk_in = 4'b0001;
      end else begin
        txdata_in    = 32'hC0000000 + i;
        txcharisk_in = 4'h0;
      end
      txvld_in = 1'b1;
      exp_q.push_back({txdata_in, 4'h0, txcharisk_in});
      tick();
    end
    txvld_in = 1'b0;
    exp_w = exp_q.pop_front();
    n_vec++;
    if ({tx_data_out, tx_charisk_out} !== exp_w) begin
      n_err++; $display("FAIL t5_last: got %h expected %h", {tx_data_out, tx_charisk_out}, exp_w);
    end
    n_vec++;
    if (forced_cnt_out !== f0) begin
      n_err++; $display("FAIL t5_forced: got %h expected %h", forced_cnt_out, f0);
    end
  endtask

  task automatic test_reset_mid();
    idle(2);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        exp_w = exp_q.pop_front();
        n_vec++;
        if ({tx_data_out, tx_charisk_out} !== exp_w) begin
          n_err++; $display("FAIL t6_data cyc %0d: got %h expected %h", i, {tx_data_out, tx_charisk_out}, exp_w);
        end
      end
      txvld_in     = 1'b1;
      txdata_in    = 32'hD0000000 + i;
      txcharisk_in = 4'h2;
      exp_q.push_back({txdata_in, 8'h02});
      if (i < 3) tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    n_vec++;
    if ({tx_data_out, tx_charisk_out} !== EXP_COMMA || txrdy_out !== 1'b0 ||
        align_state_out !== 2'b01 || forced_cnt_out !== 16'h0000) begin
      n_err++; $display("FAIL t6_async: got out=%h rdy=%b st=%b fc=%h expected out=%h rdy=0 st=01 fc=0000",
                        {tx_data_out, tx_charisk_out}, txrdy_out, align_state_out, forced_cnt_out, EXP_COMMA);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < BURST_LEN; i++) begin
      n_vec++;
      if (txrdy_out !== 1'b0 || align_state_out !== 2'b01 || {tx_data_out, tx_charisk_out} !== EXP_COMMA) begin
        n_err++; $display("FAIL t6_burst cyc %0d: got rdy=%b st=%b out=%h expected rdy=0 st=01 out=%h",
                          i, txrdy_out, align_state_out, {tx_data_out, tx_charisk_out}, EXP_COMMA);
      end
      tick();
    end
    n_vec++;
    if (txrdy_out !== 1'b1 || align_state_out !== 2'b00) begin
      n_err++; $display("FAIL t6_run: got rdy=%b st=%b expected rdy=1 st=00", txrdy_out, align_state_out);
    end
    exp_q.push_back({txdata_in, 8'h02});
    tick();
    txvld_in = 1'b0;
    exp_w = exp_q.pop_front();
    n_vec++;
    if ({tx_data_out, tx_charisk_out} !== exp_w) begin
      n_err++; $display("FAIL t6_held: got %h expected %h", {tx_data_out, tx_charisk_out}, exp_w);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    txvld_in      = 1'b0;
    resync_req_in = 1'b0;
    txdata_in     = 32'h0;
    txcharisk_in  = 4'h0;
    test_reset();
    test_burst_release();
    test_single_word();
    test_saturated();
    test_resync();
    test_comma_source();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
